// File: rtl/controller_digit_entry_if.sv
// Key-operation and committed-operand handshake bundle for the digit entry register.
// The master drives keys and consumes operands; the slave is the entry register.
interface controller_digit_entry_if #(
    parameter int W     = 27,
    parameter int CNT_W = 4
);
    logic             key_valid;
    logic             key_ready;
    logic [2:0]       key_op;
    logic [3:0]       key_digit;
    logic [W-1:0]     mag;
    logic             neg;
    logic [CNT_W-1:0] count;
    logic [3:0]       last_digit;
    logic             full;
    logic             err;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_mag;
    logic             out_neg;
    logic [CNT_W-1:0] out_count;

    modport master (
        output key_valid, key_op, key_digit, out_ready,
        input  key_ready, mag, neg, count, last_digit, full, err,
        input  out_valid, out_mag, out_neg, out_count
    );

    modport slave (
        input  key_valid, key_op, key_digit, out_ready,
        output key_ready, mag, neg, count, last_digit, full, err,
        output out_valid, out_mag, out_neg, out_count
    );
endinterface

// File: rtl/controller_digit_entry.sv
// Multi-digit signed operand entry in a configurable radix, committed over valid/ready.
// One-cycle latency from accepted key to outputs; keys are refused while an operand is pending.
module controller_digit_entry #(
    parameter int RADIX  = 10,
    parameter int DIGITS = 8,
    parameter int W      = 27,
    parameter int CNT_W  = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    controller_digit_entry_if.slave ent
);
    localparam int XW = W + 4;

    typedef enum logic [2:0] {
        OP_DIGIT  = 3'd0,
        OP_BACK   = 3'd1,
        OP_CLEAR  = 3'd2,
        OP_NEG    = 3'd3,
        OP_COMMIT = 3'd4
    } op_e;

    logic [W-1:0]      mag_q, mag_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        stk_q [DIGITS];
    logic [3:0]        stk_d [DIGITS];
    logic [3:0]        last_q, last_d;
    logic              full_q, full_d;
    logic              err_q, err_d;
    logic              ov_q, ov_d;
    logic [W-1:0]      omag_q, omag_d;
    logic              oneg_q, oneg_d;
    logic [CNT_W-1:0]  ocnt_q, ocnt_d;
    logic              accept;

    assign accept = ent.key_valid & ~ov_q;

    always_comb begin
        mag_d  = mag_q;
        neg_d  = neg_q;
        cnt_d  = cnt_q;
        stk_d  = stk_q;
        last_d = last_q;
        err_d  = 1'b0;
        ov_d   = ov_q & ~ent.out_ready;
        omag_d = omag_q;
        oneg_d = oneg_q;
        ocnt_d = ocnt_q;
        if (accept) begin
            case (op_e'(ent.key_op))
                OP_DIGIT: begin
                    if (int'(ent.key_digit) >= RADIX || cnt_q == CNT_W'(DIGITS)) begin
                        err_d = 1'b1;
                    end else begin
                        mag_d = W'(XW'(mag_q) * XW'(RADIX) + XW'(ent.key_digit));
                        for (int i = DIGITS - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
                        stk_d[0] = ent.key_digit;
                        cnt_d    = cnt_q + 1'b1;
                        last_d   = ent.key_digit;
                    end
                end
                OP_BACK: begin
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        // Subtracting the top digit first makes the division exact.
                        mag_d = W'((XW'(mag_q) - XW'(stk_q[0])) / XW'(RADIX));
                        for (int i = 0; i < DIGITS - 1; i++) stk_d[i] = stk_q[i+1];
                        stk_d[DIGITS-1] = 4'h0;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            neg_d  = 1'b0;
                            last_d = 4'hf;
                        end else begin
                            last_d = stk_d[0];
                        end
                    end
                end
                OP_CLEAR, OP_COMMIT: begin
                    if (op_e'(ent.key_op) == OP_COMMIT) begin
                        ov_d   = 1'b1;
                        omag_d = mag_q;
                        oneg_d = neg_q;
                        ocnt_d = cnt_q;
                    end
                    mag_d  = '0;
                    neg_d  = 1'b0;
                    cnt_d  = '0;
                    last_d = 4'hf;
                    for (int i = 0; i < DIGITS; i++) stk_d[i] = 4'h0;
                end
                OP_NEG:  neg_d = ~neg_q;
                default: err_d = 1'b1;
            endcase
        end
        full_d = (cnt_d == CNT_W'(DIGITS));
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mag_q  <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < DIGITS; i++) stk_q[i] <= 4'h0;
            last_q <= 4'hf;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            ov_q   <= 1'b0;
            omag_q <= '0;
            oneg_q <= 1'b0;
            ocnt_q <= '0;
        end else begin
            mag_q  <= mag_d;
            neg_q  <= neg_d;
            cnt_q  <= cnt_d;
            stk_q  <= stk_d;
            last_q <= last_d;
            full_q <= full_d;
            err_q  <= err_d;
            ov_q   <= ov_d;
            omag_q <= omag_d;
            oneg_q <= oneg_d;
            ocnt_q <= ocnt_d;
        end
    end

    assign ent.key_ready  = ~ov_q;
    assign ent.mag        = mag_q;
    assign ent.neg        = neg_q;
    assign ent.count      = cnt_q;
    assign ent.last_digit = last_q;
    assign ent.full       = full_q;
    assign ent.err        = err_q;
    assign ent.out_valid  = ov_q;
    assign ent.out_mag    = omag_q;
    assign ent.out_neg    = oneg_q;
    assign ent.out_count  = ocnt_q;
endmodule

// File: tb/tb_controller_digit_entry.sv
// Directed bench for controller_digit_entry: decimal 8-digit instance plus a hex 4-digit instance.
module tb_controller_digit_entry;
    logic Clock;
    logic Reset;
    int   n_assert;
    int   n_fail;

    controller_digit_entry_if #(.W(27), .CNT_W(4)) ifa ();
    controller_digit_entry_if #(.W(16), .CNT_W(3)) ifb ();

    controller_digit_entry #(.RADIX(10), .DIGITS(8), .W(27), .CNT_W(4)) dut_dec (
        .Clock (Clock),
        .Reset (Reset),
        .ent   (ifa)
    );

    controller_digit_entry #(.RADIX(16), .DIGITS(4), .W(16), .CNT_W(3)) dut_hex (
        .Clock (Clock),
        .Reset (Reset),
        .ent   (ifb)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int m, input bit n, input int c, input int ld);
        chk({tag, ".mag"},   64'(ifa.mag),        64'(m));
        chk({tag, ".neg"},   64'(ifa.neg),        64'(n));
        chk({tag, ".count"}, 64'(ifa.count),      64'(c));
        chk({tag, ".last"},  64'(ifa.last_digit), 64'(ld));
    endtask

    task automatic key_a(input logic [2:0] op, input logic [3:0] d);
        ifa.key_valid = 1'b1;
        ifa.key_op    = op;
        ifa.key_digit = d;
        @(posedge Clock);
        #1;
        ifa.key_valid = 1'b0;
    endtask

    task automatic key_b(input logic [2:0] op, input logic [3:0] d);
        ifb.key_valid = 1'b1;
        ifb.key_op    = op;
        ifb.key_digit = d;
        @(posedge Clock);
        #1;
        ifb.key_valid = 1'b0;
    endtask

    task automatic idle;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        ifa.key_valid = 1'b0; ifa.key_op = 3'd0; ifa.key_digit = 4'd0; ifa.out_ready = 1'b1;
        ifb.key_valid = 1'b0; ifb.key_op = 3'd0; ifb.key_digit = 4'd0; ifb.out_ready = 1'b1;

        #22;
        chk_a("rst", 0, 1'b0, 0, 4'hf);
        chk("rst.full",      64'(ifa.full),      64'd0);
        chk("rst.err",       64'(ifa.err),       64'd0);
        chk("rst.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst.out_mag",   64'(ifa.out_mag),   64'd0);
        chk("rst.out_neg",   64'(ifa.out_neg),   64'd0);
        chk("rst.out_count", 64'(ifa.out_count), 64'd0);
        chk("rst.key_ready", 64'(ifa.key_ready), 64'd1);
        @(negedge Clock);
        Reset = 1'b1;
        idle();

        // 1,2,3 then commit with the consumer ready
        key_a(3'd0, 4'd1);
        chk_a("d1", 1, 1'b0, 1, 1);
        key_a(3'd0, 4'd2);
        key_a(3'd0, 4'd3);
        chk_a("d123", 123, 1'b0, 3, 3);
        key_a(3'd4, 4'd0);
        chk("c1.out_valid", 64'(ifa.out_valid), 64'd1);
        chk("c1.out_mag",   64'(ifa.out_mag),   64'd123);
        chk("c1.out_count", 64'(ifa.out_count), 64'd3);
        chk("c1.out_neg",   64'(ifa.out_neg),   64'd0);
        chk("c1.key_ready", 64'(ifa.key_ready), 64'd0);
        chk_a("c1.entry", 0, 1'b0, 0, 4'hf);
        idle();
        chk("c1.drop",      64'(ifa.out_valid), 64'd0);
        chk("c1.ready",     64'(ifa.key_ready), 64'd1);

        // backspace and negate
        key_a(3'd0, 4'd4);
        key_a(3'd0, 4'd5);
        key_a(3'd0, 4'd6);
        chk_a("d456", 456, 1'b0, 3, 6);
        key_a(3'd1, 4'd0);
        chk_a("b45", 45, 1'b0, 2, 5);
        key_a(3'd1, 4'd0);
        key_a(3'd3, 4'd0);
        key_a(3'd0, 4'd9);
        chk_a("d49", 49, 1'b1, 2, 9);
        key_a(3'd1, 4'd0);
        chk_a("b4", 4, 1'b1, 1, 4);
        key_a(3'd1, 4'd0);
        chk_a("b0", 0, 1'b0, 0, 4'hf);
        key_a(3'd1, 4'd0);
        chk("b_empty.err", 64'(ifa.err), 64'd1);
        chk_a("b_empty", 0, 1'b0, 0, 4'hf);
        idle();
        chk("b_empty.err_end", 64'(ifa.err), 64'd0);

        // reserved ops back to back, and NEG while empty
        key_a(3'd5, 4'd0);
        chk("rsv5.err", 64'(ifa.err), 64'd1);
        key_a(3'd7, 4'd0);
        chk("rsv7.err", 64'(ifa.err), 64'd1);
        key_a(3'd3, 4'd0);
        chk("neg_empty.err", 64'(ifa.err), 64'd0);
        chk_a("neg_empty", 0, 1'b1, 0, 4'hf);
        key_a(3'd3, 4'd0);
        chk("neg_toggle", 64'(ifa.neg), 64'd0);

        // fill to capacity
        for (int i = 0; i < 8; i++) key_a(3'd0, 4'd9);
        chk_a("full8", 99999999, 1'b0, 8, 9);
        chk("full8.full", 64'(ifa.full), 64'd1);
        key_a(3'd0, 4'd9);
        chk("d9th.err", 64'(ifa.err), 64'd1);
        chk_a("d9th", 99999999, 1'b0, 8, 9);
        key_a(3'd1, 4'd0);
        chk("unfull", 64'(ifa.full), 64'd0);
        key_a(3'd0, 4'ha);
        chk("dA.err", 64'(ifa.err), 64'd1);
        chk_a("dA", 9999999, 1'b0, 7, 9);
        key_a(3'd2, 4'd0);
        chk_a("clear", 0, 1'b0, 0, 4'hf);
        chk("clear.err", 64'(ifa.err), 64'd0);

        // stalled consumer while a digit key is held
        key_a(3'd0, 4'd7);
        ifa.out_ready = 1'b0;
        key_a(3'd4, 4'd0);
        ifa.key_valid = 1'b1;
        ifa.key_op    = 3'd0;
        ifa.key_digit = 4'd3;
        for (int i = 0; i < 5; i++) begin
            chk("stall.out_valid", 64'(ifa.out_valid), 64'd1);
            chk("stall.out_mag",   64'(ifa.out_mag),   64'd7);
            chk("stall.key_ready", 64'(ifa.key_ready), 64'd0);
            chk("stall.err",       64'(ifa.err),       64'd0);
            chk("stall.mag",       64'(ifa.mag),       64'd0);
            idle();
        end
        ifa.out_ready = 1'b1;
        idle();
        chk("hs.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("hs.mag",       64'(ifa.mag),       64'd0);
        idle();
        ifa.key_valid = 1'b0;
        chk_a("after_hs", 3, 1'b0, 1, 3);

        // hex instance
        for (int i = 0; i < 4; i++) key_b(3'd0, 4'hf);
        chk("hex.mag",  64'(ifb.mag),  64'hffff);
        chk("hex.full", 64'(ifb.full), 64'd1);
        key_b(3'd4, 4'd0);
        chk("hex.out_mag",   64'(ifb.out_mag),   64'hffff);
        chk("hex.out_count", 64'(ifb.out_count), 64'd4);
        idle();
        chk("hex.drop", 64'(ifb.out_valid), 64'd0);
        key_b(3'd4, 4'd0);
        chk("hex0.out_valid", 64'(ifb.out_valid), 64'd1);
        chk("hex0.out_count", 64'(ifb.out_count), 64'd0);
        chk("hex0.out_mag",   64'(ifb.out_mag),   64'd0);
        idle();

        // asynchronous reset mid-handshake and mid-entry
        key_a(3'd2, 4'd0);
        key_a(3'd0, 4'd8);
        key_a(3'd0, 4'd1);
        key_a(3'd0, 4'd5);
        ifa.out_ready = 1'b0;
        key_a(3'd4, 4'd0);
        key_b(3'd0, 4'd1);
        key_b(3'd0, 4'd2);
        chk("pre_rst.out_count", 64'(ifa.out_count), 64'd3);
        chk("pre_rst.out_mag",   64'(ifa.out_mag),   64'd815);
        chk("pre_rst.hex_count", 64'(ifb.count),     64'd2);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst.out_valid", 64'(ifa.out_valid), 64'd0);
        chk("arst.out_mag",   64'(ifa.out_mag),   64'd0);
        chk("arst.out_count", 64'(ifa.out_count), 64'd0);
        chk("arst.key_ready", 64'(ifa.key_ready), 64'd1);
        chk("arst.hex_count", 64'(ifb.count),     64'd0);
        chk("arst.hex_mag",   64'(ifb.mag),       64'd0);
        chk("arst.hex_last",  64'(ifb.last_digit), 64'hf);
        @(negedge Clock);
        Reset = 1'b1;
        ifa.out_ready = 1'b1;
        idle();
        chk_a("post_rst", 0, 1'b0, 0, 4'hf);
        chk("post_rst.out_valid", 64'(ifa.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
